// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants for the dual-port byte-enabled memory
//
// Purpose: response error encoding and default geometry used by dp_byte_mem
//          and its per-port response slot.
// Ports:   none (package).
package mem_pkg;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_DEPTH_BYTES = 1024;

   // Response error codes presented on P_rsp_err.
   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_RANGE    = 2'b10;

endpackage

// File: rtl/mem_rsp_slot.sv
// rtl/mem_rsp_slot.sv - single-entry response register with request-ready logic
//
// Purpose: holds one port's response (rdata, err) from acceptance until it is
//          consumed, and throttles new requests while a response is stalled.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (ready low only while a held
//                       response is not being consumed)
//   accept              request taken on this edge (req_valid && req_ready)
//   rdata_in, err_in    response contents captured on acceptance
//   rsp_valid/rsp_ready response handshake
//   rdata, rsp_err      registered response, stable until consumed
module mem_rsp_slot
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   output logic              accept,
   input  logic [DATA_W-1:0] rdata_in,
   input  logic [1:0]        err_in,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rdata,
   output logic [1:0]        rsp_err
);

   // A consumed response frees the slot on the same edge, so back-to-back
   // requests run at one per cycle whenever the consumer keeps up.
   assign req_ready = !(rsp_valid && !rsp_ready);
   assign accept    = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rdata     <= '0;
         rsp_err   <= ERR_OK;
      end else if (accept) begin
         rsp_valid <= 1'b1;
         rdata     <= rdata_in;
         rsp_err   <= err_in;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/dp_byte_mem.sv
// rtl/dp_byte_mem.sv - dual-port byte-enabled memory with checked addressing
//
// Purpose: two independent request/response ports onto one word-organised
//          memory. Each accepted request returns one response a cycle later
//          carrying the pre-write word; be=0 is a read. Misaligned or
//          out-of-range requests respond with an error and do not write.
//          Same-word writes from both ports merge per byte, port A winning
//          overlapping bytes; such cycles are counted in coll_cnt.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   {a,b}_req_valid/_req_ready        request handshake
//   {a,b}_addr, _be, _wdata           byte address, byte enables, write data
//   {a,b}_rsp_valid/_rsp_ready        response handshake
//   {a,b}_rdata, _rsp_err             read data (old contents), error code
//   coll_cnt                          saturating same-byte write collision count
module dp_byte_mem
   import mem_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int DEPTH_BYTES = DEF_DEPTH_BYTES,
   parameter int ADDR_W      = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                a_req_valid,
   output logic                a_req_ready,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W/8-1:0] a_be,
   input  logic [DATA_W-1:0]   a_wdata,
   output logic                a_rsp_valid,
   input  logic                a_rsp_ready,
   output logic [DATA_W-1:0]   a_rdata,
   output logic [1:0]          a_rsp_err,
   input  logic                b_req_valid,
   output logic                b_req_ready,
   input  logic [ADDR_W-1:0]   b_addr,
   input  logic [DATA_W/8-1:0] b_be,
   input  logic [DATA_W-1:0]   b_wdata,
   output logic                b_rsp_valid,
   input  logic                b_rsp_ready,
   output logic [DATA_W-1:0]   b_rdata,
   output logic [1:0]          b_rsp_err,
   output logic [15:0]         coll_cnt
);

   localparam int NB          = DATA_W / 8;
   localparam int OFF         = $clog2(NB);
   localparam int DEPTH_WORDS = DEPTH_BYTES / NB;
   localparam int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   // Range is checked one bit wider than the address so a request near the
   // top of the address space cannot wrap back into the array.
   function automatic logic [1:0] addr_err(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W:0] end_addr;
      end_addr = {1'b0, addr} + (ADDR_W+1)'(NB);
      if (addr[OFF-1:0] != '0)
         return ERR_MISALIGN;
      if (end_addr > (ADDR_W+1)'(DEPTH_BYTES))
         return ERR_RANGE;
      return ERR_OK;
   endfunction

   logic [1:0]        a_err, b_err;
   logic [IDX_W-1:0]  a_idx, b_idx;
   logic [DATA_W-1:0] a_rd, b_rd;
   logic              a_acc, b_acc;
   logic              a_wr, b_wr;
   logic              coll;

   assign a_err = addr_err(a_addr);
   assign b_err = addr_err(b_addr);
   assign a_idx = a_addr[OFF +: IDX_W];
   assign b_idx = b_addr[OFF +: IDX_W];

   // Asynchronous read sampled into the response slot on the accepting edge,
   // so both ports always see contents from before that edge's writes.
   assign a_rd = (a_err == ERR_OK) ? mem[a_idx] : '0;
   assign b_rd = (b_err == ERR_OK) ? mem[b_idx] : '0;

   // rst_n gates writes because the slots still report ready during reset.
   assign a_wr = rst_n && a_acc && (a_err == ERR_OK) && (a_be != '0);
   assign b_wr = rst_n && b_acc && (b_err == ERR_OK) && (b_be != '0);
   assign coll = a_wr && b_wr && (a_idx == b_idx) && ((a_be & b_be) != '0);

   mem_rsp_slot #(.DATA_W(DATA_W)) u_slot_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (a_req_valid),
      .req_ready (a_req_ready),
      .accept    (a_acc),
      .rdata_in  (a_rd),
      .err_in    (a_err),
      .rsp_valid (a_rsp_valid),
      .rsp_ready (a_rsp_ready),
      .rdata     (a_rdata),
      .rsp_err   (a_rsp_err)
   );

   mem_rsp_slot #(.DATA_W(DATA_W)) u_slot_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (b_req_valid),
      .req_ready (b_req_ready),
      .accept    (b_acc),
      .rdata_in  (b_rd),
      .err_in    (b_err),
      .rsp_valid (b_rsp_valid),
      .rsp_ready (b_rsp_ready),
      .rdata     (b_rdata),
      .rsp_err   (b_rsp_err)
   );

   // Memory is deliberately not reset. Port A is written last so its bytes
   // win wherever both ports enable the same byte of the same word.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (b_wr && b_be[i])
            mem[b_idx][8*i +: 8] <= b_wdata[8*i +: 8];
         if (a_wr && a_be[i])
            mem[a_idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         coll_cnt <= '0;
      else if (coll && (coll_cnt != 16'hFFFF))
         coll_cnt <= coll_cnt + 16'd1;
   end

endmodule

// File: doc/dp_byte_mem.md
DP_BYTE_MEM -- requirements
Module: dp_byte_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, port data width in bits (32 or 64).
REQ-002 SHALL have parameter DEPTH_BYTES, default 1024, memory size in bytes (power of two, ≥ DATA_W/8).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have, for each port P in {a,b}: P_req_valid  in  1  request present.
REQ-007 SHALL have P_req_ready  out  1  request accepted when valid&&ready.
REQ-008 SHALL have P_addr  in  ADDR_W  byte address.
REQ-009 SHALL have P_be  in  DATA_W/8  byte write enables; all-zero means read.
REQ-010 SHALL have P_wdata  in  DATA_W  write data, byte i = bits [8i+7:8i], little-endian.
REQ-011 SHALL have P_rsp_valid  out  1  response present.
REQ-012 SHALL have P_rsp_ready  in  1  response consumed when valid&&ready.
REQ-013 SHALL have P_rdata  out  DATA_W  read data (pre-write contents).
REQ-014 SHALL have P_rsp_err  out  2  00 OK, 01 MISALIGN, 10 RANGE.
REQ-015 SHALL have coll_cnt  out  16  saturating count of overlapping-byte write collisions.

Function
REQ-016 Each port SHALL return exactly one response per accepted request, one cycle after acceptance.
REQ-017 P_req_ready SHALL be 0 while P_rsp_valid=1 and P_rsp_ready=0; otherwise 1.
REQ-018 Response SHALL be held stable (rdata, err) until consumed.
REQ-019 Request with P_addr not a multiple of DATA_W/8 SHALL respond err=01, rdata=0, no write.
REQ-020 Request with P_addr+DATA_W/8 > DEPTH_BYTES SHALL respond err=10, rdata=0, no write; no address wrap.
REQ-021 MISALIGN SHALL take precedence over RANGE.
REQ-022 Read data SHALL be memory contents before any same-edge write, both same-port and cross-port.
REQ-023 Accepted valid write SHALL update only bytes with P_be[i]=1 on the accepting edge.
REQ-024 When both ports write the same address in the same cycle, overlapping enabled bytes SHALL take port A data; non-overlapping bytes SHALL take their own port's data.
REQ-025 Each cycle with ≥1 overlapping enabled byte SHALL increment coll_cnt by 1, saturating at 16'hFFFF.
REQ-026 Ports SHALL be fully independent in handshake; backpressure on one SHALL not stall the other.
REQ-027 A write SHALL always produce a response (rdata = old contents) even if no read was intended.

Reset
REQ-028 While rst_n=0: P_rsp_valid=0, P_rdata=0, P_rsp_err=00, coll_cnt=0, P_req_ready=1.
REQ-029 Reset SHALL discard pending responses; no write SHALL occur on an edge where rst_n=0.
REQ-030 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-031 Package mem_pkg SHALL hold the rsp_err encoding constants and default DATA_W/DEPTH_BYTES.
REQ-032 One sub-module mem_rsp_slot (response register + ready logic) SHALL be instantiated per port.

Verification
REQ-033 A writes 0xDEADBEEF be=1111 @0x10; A reads 0x10 -> rsp next cycle, rdata=0xDEADBEEF, err=00.
REQ-034 Same cycle: A writes 0x11111111 be=0011 @0x20, B writes 0x22222222 be=0110 @0x20 -> word=0x??221111 (bytes 0,1 from A, byte 2 from B), coll_cnt=1.
REQ-035 B read @0x22 -> err=01, rdata=0; B read @DEPTH_BYTES-2 -> err=01; B read @DEPTH_BYTES -> err=10; memory unchanged.
REQ-036 Hold a_rsp_ready=0 for 3 cycles after read -> a_req_ready=0, rdata stable; B continues one response/cycle throughout.
REQ-037 A writes 0xCAFEF00D @0x30 while B reads 0x30 same cycle -> B gets old value; next B read gets 0xCAFEF00D.
REQ-038 Assert rst_n=0 with responses pending -> rsp_valid=0, coll_cnt=0 immediately; after release, read returns pre-reset memory data.
